cipo_combined_phase_selector: RTL and testbench



---
 rtl/cipo_pkg.sv | 23 ++
 rtl/cipo_word_extractor.sv | 21 ++
 rtl/cipo_combined_phase_selector.sv | 45 ++++
 tb/tb_cipo_combined_phase_selector.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/cipo_pkg.sv
// Shared constants and types for recovering DDR CIPO words from the 4x oversampled capture.
package cipo_pkg;

    localparam int NUM_SAMPLES = 74;
    localparam int WORD_BITS   = 16;
    localparam int OVERSAMPLE  = 4;
    localparam int MAX_PHASE   = 11;
    localparam int DDR_OFFSET  = 2;
    localparam int OFFSET_BITS = 7;

    typedef logic [NUM_SAMPLES-1:0] oversample_t;
    typedef logic [WORD_BITS-1:0]   cipo_word_t;
    typedef logic [OFFSET_BITS-1:0] sample_offset_t;

    // Phases past MAX_PHASE would push the B word's last sample beyond the capture.
    function automatic logic [3:0] saturate_phase(input logic [3:0] phase);
        if (phase > 4'(MAX_PHASE)) begin
            return 4'(MAX_PHASE);
        end
        return phase;
    endfunction

endpackage

// File: rtl/cipo_word_extractor.sv
// Picks one 16-bit word out of the oversampled capture: every OVERSAMPLE-th sample from start, MSB first.
module cipo_word_extractor
    import cipo_pkg::*;
(
    input  oversample_t    samples,
    input  sample_offset_t start,
    output cipo_word_t     word
);

    oversample_t shifted;

    // Shifting first keeps all later selects constant and in range.
    always_comb begin
        shifted = samples >> start;
        word    = '0;
        for (int k = 0; k < WORD_BITS; k++) begin
            word[WORD_BITS-1-k] = shifted[OVERSAMPLE*k];
        end
    end

endmodule

// File: rtl/cipo_combined_phase_selector.sv
// Recovers the A and B DDR register words from one 4x oversampled CIPO line at a selectable phase.
module cipo_combined_phase_selector
    import cipo_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  phase_select,
    input  logic [73:0] CIPO4x,
    output logic [31:0] CIPO
);

    logic [3:0]     phase_eff;
    sample_offset_t offset_a;
    sample_offset_t offset_b;
    cipo_word_t     word_a;
    cipo_word_t     word_b;

    always_comb begin
        phase_eff = saturate_phase(phase_select);
        offset_a  = sample_offset_t'(phase_eff);
        offset_b  = offset_a + sample_offset_t'(DDR_OFFSET);
    end

    cipo_word_extractor u_extract_a (
        .samples (CIPO4x),
        .start   (offset_a),
        .word    (word_a)
    );

    // B is sampled half an SCLK period after A.
    cipo_word_extractor u_extract_b (
        .samples (CIPO4x),
        .start   (offset_b),
        .word    (word_b)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            CIPO <= '0;
        end else begin
            CIPO <= {word_b, word_a};
        end
    end

endmodule

// File: tb/tb_cipo_combined_phase_selector.sv
// Directed bench for cipo_combined_phase_selector with hand-computed expected words.
module tb_cipo_combined_phase_selector;
    import cipo_pkg::*;

    logic        clk;
    logic        rst;
    logic [3:0]  phase_select;
    logic [73:0] CIPO4x;
    logic [31:0] CIPO;

    int vectors;
    int miscompares;

    cipo_combined_phase_selector dut (
        .clk          (clk),
        .rst          (rst),
        .phase_select (phase_select),
        .CIPO4x       (CIPO4x),
        .CIPO         (CIPO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [73:0] stride_vec();
        logic [73:0] v;
        v = '0;
        for (int k = 0; k < 16; k++) v[4*k] = 1'b1;
        return v;
    endfunction

    task automatic edge_then_settle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst          = 1'b1;
        CIPO4x       = '1;
        phase_select = 4'd0;
        #1;
        vectors++;
        if (CIPO !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_immediate: got %h expected %h", CIPO, 32'h0);
        end
        edge_then_settle();
        vectors++;
        if (CIPO !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_hold: got %h expected %h", CIPO, 32'h0);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        vectors++;
        if (CIPO !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_release_no_edge: got %h expected %h", CIPO, 32'h0);
        end
        edge_then_settle();
        vectors++;
        if (CIPO !== 32'hFFFF_FFFF) begin
            miscompares++;
            $display("FAIL reset_first_update: got %h expected %h", CIPO, 32'hFFFF_FFFF);
        end
    endtask

    task automatic test_stride();
        @(negedge clk);
        CIPO4x       = stride_vec();
        phase_select = 4'd0;
        edge_then_settle();
        vectors++;
        if (CIPO !== 32'h0000_FFFF) begin
            miscompares++;
            $display("FAIL stride_phase0: got %h expected %h", CIPO, 32'h0000_FFFF);
        end
        @(negedge clk);
        phase_select = 4'd2;
        edge_then_settle();
        vectors++;
        if (CIPO !== 32'hFFFE_0000) begin
            miscompares++;
            $display("FAIL stride_phase2: got %h expected %h", CIPO, 32'hFFFE_0000);
        end
    endtask

    task automatic test_saturation();
        logic [3:0] phases [3];
        phases[0] = 4'd11;
        phases[1] = 4'd12;
        phases[2] = 4'd15;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            CIPO4x       = '0;
            CIPO4x[73]   = 1'b1;
            phase_select = phases[i];
            edge_then_settle();
            vectors++;
            if (CIPO !== 32'h0001_0000) begin
                miscompares++;
                $display("FAIL saturation_phase%0d: got %h expected %h", phases[i], CIPO, 32'h0001_0000);
            end
        end
    endtask

    task automatic test_sweep();
        logic [15:0] a;
        logic [15:0] b;
        logic [73:0] v;
        a = 16'hA5C3;
        b = 16'h3C96;
        for (int p = 0; p <= 11; p++) begin
            for (int i = 0; i < 74; i++) v[i] = 1'($urandom_range(0, 1));
            for (int k = 0; k < 16; k++) begin
                v[p + 4*k]     = a[15-k];
                v[p + 4*k + 2] = b[15-k];
            end
            @(negedge clk);
            CIPO4x       = v;
            phase_select = 4'(p);
            edge_then_settle();
            vectors++;
            if (CIPO !== 32'h3C96_A5C3) begin
                miscompares++;
                $display("FAIL sweep_phase%0d: got %h expected %h", p, CIPO, 32'h3C96_A5C3);
            end
        end
    endtask

    task automatic test_latency_and_midstream_reset();
        @(negedge clk);
        CIPO4x       = stride_vec();
        phase_select = 4'd0;
        edge_then_settle();
        @(negedge clk);
        phase_select = 4'd2;
        #1;
        vectors++;
        if (CIPO !== 32'h0000_FFFF) begin
            miscompares++;
            $display("FAIL latency_before_edge: got %h expected %h", CIPO, 32'h0000_FFFF);
        end
        edge_then_settle();
        vectors++;
        if (CIPO !== 32'hFFFE_0000) begin
            miscompares++;
            $display("FAIL latency_after_edge: got %h expected %h", CIPO, 32'hFFFE_0000);
        end
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        vectors++;
        if (CIPO !== 32'h0) begin
            miscompares++;
            $display("FAIL midstream_reset_async: got %h expected %h", CIPO, 32'h0);
        end
        #1;
        rst = 1'b0;
        #1;
        vectors++;
        if (CIPO !== 32'h0) begin
            miscompares++;
            $display("FAIL midstream_reset_pulse_hold: got %h expected %h", CIPO, 32'h0);
        end
        edge_then_settle();
        vectors++;
        if (CIPO !== 32'hFFFE_0000) begin
            miscompares++;
            $display("FAIL midstream_reset_resume: got %h expected %h", CIPO, 32'hFFFE_0000);
        end
    endtask

    initial begin
        vectors      = 0;
        miscompares  = 0;
        rst          = 1'b1;
        phase_select = '0;
        CIPO4x       = '0;
        test_reset();
        test_stride();
        test_saturation();
        test_sweep();
        test_latency_and_midstream_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
